audio_tone_gen: RTL and testbench

//  Consumes audioEn/audioSel/audioVol from the decode stage and plays one fixed-length note.
//  The note is a square-wave tone; its volume sets the PWM duty cycle.

---
 rtl/audio_tone_gen.sv | 188 ++++++++++++++++++
 tb/tb_audio_tone_gen.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/audio_tone_gen.sv
// audio_tone_gen: plays one fixed-length square-wave note per decode strobe.
// The note volume sets the PWM duty cycle. A new strobe restarts the note.
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous, active-high; clears all state
//   audio_en   one-cycle strobe: latch audio_sel/audio_vol and (re)start
//   audio_sel  tone select 1..15, 0 = stop/silence
//   audio_vol  volume 0..31
//   pwm_out    registered PWM output for the RC-filtered audio pin
//   amp        registered instantaneous amplitude (0 or volume)
//   busy       registered, high while a note is playing
//
// Optional feature macro: AUDIO_ENVELOPE_EN
//   When defined, the volume decays by one step every ENV_STEP cycles.
//   The note ends early once the volume reaches 0.

module audio_tone_gen #(
    parameter int NOTE_LEN = 2500000,
    parameter int DIV_W    = 16,
    parameter int DUR_W    = 24,
    parameter int ENV_STEP = 78125
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       audio_en,
    input  logic [3:0] audio_sel,
    input  logic [4:0] audio_vol,
    output logic       pwm_out,
    output logic [4:0] amp,
    output logic       busy
);

    // The tone table needs 16 bits; the duration counter must hold NOTE_LEN-1.
    if (NOTE_LEN < 1 || ENV_STEP < 1 || DIV_W < 16 ||
        ((NOTE_LEN - 1) >> DUR_W) != 0) begin : g_bad_cfg
        $error("audio_tone_gen: invalid parameters");
    end

    typedef enum logic {
        IDLE,
        PLAY
    } state_t;

    localparam logic [DUR_W-1:0] DUR_LAST = DUR_W'(NOTE_LEN - 1);

    state_t             state_q, state_d;
    logic [3:0]         sel_q, sel_d;
    logic [4:0]         vol_q, vol_d;
    logic               phase_q, phase_d;
    logic [DIV_W-1:0]   tone_q, tone_d;
    logic [DUR_W-1:0]   dur_q, dur_d;
    logic [4:0]         amp_d;
    logic [4:0]         pwm_cnt;

`ifdef AUDIO_ENVELOPE_EN
    localparam int ENV_W = (ENV_STEP > 1) ? $clog2(ENV_STEP) : 1;
    localparam logic [ENV_W-1:0] ENV_LAST = ENV_W'(ENV_STEP - 1);

    logic [ENV_W-1:0]   env_q, env_d;
`endif

    // Half-period minus one, C4..C6 at 25 MHz.
    function automatic logic [DIV_W-1:0] half_m1(input logic [3:0] s);
        logic [15:0] h;
        unique case (s)
            4'd1:    h = 16'd47778;
            4'd2:    h = 16'd42566;
            4'd3:    h = 16'd37922;
            4'd4:    h = 16'd35793;
            4'd5:    h = 16'd31888;
            4'd6:    h = 16'd28409;
            4'd7:    h = 16'd25310;
            4'd8:    h = 16'd23889;
            4'd9:    h = 16'd21283;
            4'd10:   h = 16'd18961;
            4'd11:   h = 16'd17897;
            4'd12:   h = 16'd15944;
            4'd13:   h = 16'd14205;
            4'd14:   h = 16'd12655;
            4'd15:   h = 16'd11945;
            default: h = 16'd1;
        endcase
        return DIV_W'(h - 16'd1);
    endfunction

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        vol_d   = vol_q;
        phase_d = phase_q;
        tone_d  = tone_q;
        dur_d   = dur_q;
`ifdef AUDIO_ENVELOPE_EN
        env_d   = env_q;
`endif

        if (audio_en) begin
            sel_d = audio_sel;
            vol_d = audio_vol;
`ifdef AUDIO_ENVELOPE_EN
            env_d = ENV_LAST;
`endif
            if (audio_sel == 4'd0) begin
                state_d = IDLE;
                phase_d = 1'b0;
                tone_d  = '0;
                dur_d   = '0;
            end else begin
                state_d = PLAY;
                phase_d = 1'b1;
                tone_d  = half_m1(audio_sel);
                dur_d   = DUR_LAST;
            end
        end else if (state_q == PLAY) begin
            if (tone_q == '0) begin
                tone_d  = half_m1(sel_q);
                phase_d = ~phase_q;
            end else begin
                tone_d  = tone_q - 1'b1;
            end

`ifdef AUDIO_ENVELOPE_EN
            // Volume 1 (or 0) decays to 0 here, which ends the note.
            if (env_q == '0) begin
                env_d = ENV_LAST;
                if (vol_q <= 5'd1) begin
                    vol_d   = 5'd0;
                    state_d = IDLE;
                    phase_d = 1'b0;
                end else begin
                    vol_d   = vol_q - 5'd1;
                end
            end else begin
                env_d = env_q - 1'b1;
            end
`endif

            // Placed last so the end of the note overrides a tone toggle.
            if (dur_q == '0) begin
                state_d = IDLE;
                phase_d = 1'b0;
            end else begin
                dur_d   = dur_q - 1'b1;
            end
        end

        amp_d = (state_d == PLAY && phase_d) ? vol_d : 5'd0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            sel_q   <= '0;
            vol_q   <= '0;
            phase_q <= 1'b0;
            tone_q  <= '0;
            dur_q   <= '0;
            amp     <= '0;
            busy    <= 1'b0;
            pwm_cnt <= '0;
            pwm_out <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            vol_q   <= vol_d;
            phase_q <= phase_d;
            tone_q  <= tone_d;
            dur_q   <= dur_d;
            amp     <= amp_d;
            busy    <= (state_d == PLAY);
            // Free-running; strobes never realign the PWM frame.
            pwm_cnt <= pwm_cnt + 5'd1;
            pwm_out <= (pwm_cnt < amp);
        end
    end

`ifdef AUDIO_ENVELOPE_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            env_q <= '0;
        end else begin
            env_q <= env_d;
        end
    end
`endif

endmodule

// File: tb/tb_audio_tone_gen.sv
// tb_audio_tone_gen: self-checking bench for audio_tone_gen.
// Short-note instance for most scenarios, long-note instance for tone toggling.

module tb_audio_tone_gen;

    localparam int NL_S = 100;
    localparam int ES_S = 10;
    localparam int NL_L = 25000;
    localparam int ES_L = 100000;

    logic       clk = 1'b0;
    logic       reset = 1'b1;

    logic       en_s = 1'b0;
    logic [3:0] sel_s = '0;
    logic [4:0] vol_s = '0;
    logic       pwm_s;
    logic [4:0] amp_s;
    logic       busy_s;

    logic       en_l = 1'b0;
    logic [3:0] sel_l = '0;
    logic [4:0] vol_l = '0;
    logic       pwm_l;
    logic [4:0] amp_l;
    logic       busy_l;

    int total = 0;
    int bad = 0;
    int ecnt = 0;

    int half_tab [16] = '{1, 47778, 42566, 37922, 35793, 31888, 28409,
                          25310, 23889, 21283, 18961, 17897, 15944,
                          14205, 12655, 11945};

    always #5 clk = ~clk;

    // Edges since reset release; the PWM counter equals this modulo 32.
    always @(posedge clk) begin
        if (reset) ecnt <= 0;
        else       ecnt <= ecnt + 1;
    end

    audio_tone_gen #(
        .NOTE_LEN(NL_S), .DIV_W(16), .DUR_W(24), .ENV_STEP(ES_S)
    ) dut_s (
        .clk(clk), .reset(reset), .audio_en(en_s),
        .audio_sel(sel_s), .audio_vol(vol_s),
        .pwm_out(pwm_s), .amp(amp_s), .busy(busy_s)
    );

    audio_tone_gen #(
        .NOTE_LEN(NL_L), .DIV_W(16), .DUR_W(24), .ENV_STEP(ES_L)
    ) dut_l (
        .clk(clk), .reset(reset), .audio_en(en_l),
        .audio_sel(sel_l), .audio_vol(vol_l),
        .pwm_out(pwm_l), .amp(amp_l), .busy(busy_l)
    );

    // Note length in cycles for a given start volume.
    function automatic int nlen(bit lng, int vol);
        int nl = lng ? NL_L : NL_S;
`ifdef AUDIO_ENVELOPE_EN
        int es = lng ? ES_L : ES_S;
        int v = (vol == 0) ? 1 : vol;
        if (es * v < nl) return es * v;
`else
        if (vol < 0) return 0;
`endif
        return nl;
    endfunction

    // k = cycles after the strobe cycle (1 = first cycle outputs react).
    function automatic bit exp_busy(bit lng, int sel, int vol, int k);
        return sel != 0 && k >= 1 && k <= nlen(lng, vol);
    endfunction

    function automatic int exp_amp(bit lng, int sel, int vol, int k);
        int half = half_tab[sel];
        int v = vol;
        if (!exp_busy(lng, sel, vol, k)) return 0;
`ifdef AUDIO_ENVELOPE_EN
        v = vol - (k - 1) / (lng ? ES_L : ES_S);
        if (v < 0) v = 0;
`endif
        if (((k - 1) / half) % 2 != 0) return 0;
        return v;
    endfunction

    // pwm_out after this edge reflects the previous count and amplitude.
    function automatic bit exp_pwm(int prev_amp);
        return ((ecnt - 1) % 32) < prev_amp;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input bit lng, input int sel, input int vol);
        if (lng) begin
            en_l = 1'b1; sel_l = 4'(sel); vol_l = 5'(vol);
        end else begin
            en_s = 1'b1; sel_s = 4'(sel); vol_s = 5'(vol);
        end
        step();
        en_s = 1'b0;
        en_l = 1'b0;
    endtask

    // Plays sel/vol on the short instance and checks kmax cycles.
    task automatic play_short(input string nm, input int sel,
                              input int vol, input int kmax);
        int pa = 0;
        int ea;
        bit eb;
        strobe(1'b0, sel, vol);
        for (int k = 1; k <= kmax; k++) begin
            if (k > 1) step();
            eb = exp_busy(1'b0, sel, vol, k);
            ea = exp_amp(1'b0, sel, vol, k);
            total++;
            if (busy_s !== eb) begin
                bad++;
                $display("FAIL %s_busy k=%0d got=%b want=%b",
                         nm, k, busy_s, eb);
            end
            total++;
            if (amp_s !== 5'(ea)) begin
                bad++;
                $display("FAIL %s_amp k=%0d got=%0d want=%0d",
                         nm, k, amp_s, ea);
            end
            if (k > 1) begin
                total++;
                if (pwm_s !== exp_pwm(pa)) begin
                    bad++;
                    $display("FAIL %s_pwm k=%0d got=%b want=%b",
                             nm, k, pwm_s, exp_pwm(pa));
                end
            end
            pa = ea;
        end
    endtask

    task automatic test_reset();
        repeat (5) step();
        total++;
        if ({pwm_s, amp_s, busy_s} !== 7'd0) begin
            bad++;
            $display("FAIL reset_short got=%b want=0", {pwm_s, amp_s, busy_s});
        end
        total++;
        if ({pwm_l, amp_l, busy_l} !== 7'd0) begin
            bad++;
            $display("FAIL reset_long got=%b want=0", {pwm_l, amp_l, busy_l});
        end
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            total++;
            if ({pwm_s, amp_s, busy_s} !== 7'd0) begin
                bad++;
                $display("FAIL idle_out i=%0d got=%b want=0",
                         i, {pwm_s, amp_s, busy_s});
            end
        end
    endtask

    task automatic test_tone_full();
        play_short("full", 15, 31, NL_S + 3);
    endtask

    task automatic test_tone_toggle();
        int pa = 0;
        int ea;
        bit eb;
        strobe(1'b1, 15, 31);
        for (int k = 1; k <= NL_L + 3; k++) begin
            if (k > 1) step();
            eb = exp_busy(1'b1, 15, 31, k);
            ea = exp_amp(1'b1, 15, 31, k);
            total++;
            if (busy_l !== eb) begin
                bad++;
                $display("FAIL toggle_busy k=%0d got=%b want=%b", k, busy_l, eb);
            end
            total++;
            if (amp_l !== 5'(ea)) begin
                bad++;
                $display("FAIL toggle_amp k=%0d got=%0d want=%0d", k, amp_l, ea);
            end
            if (k > 1) begin
                total++;
                if (pwm_l !== exp_pwm(pa)) begin
                    bad++;
                    $display("FAIL toggle_pwm k=%0d got=%b want=%b",
                             k, pwm_l, exp_pwm(pa));
                end
            end
            pa = ea;
        end
    endtask

    task automatic test_retrigger();
        play_short("retrig_a", 1, 16, 49);
        play_short("retrig_b", 2, 8, NL_S + 3);
    endtask

    task automatic test_stop();
        play_short("stop_a", 3, int'($urandom_range(1, 31)), 20);
        play_short("stop_b", 0, int'($urandom_range(0, 31)), 10);
    endtask

    task automatic test_vol_zero();
        play_short("vol0", 5, 0, NL_S + 3);
    endtask

    task automatic test_envelope();
        play_short("env", 4, 3, 40);
    endtask

    task automatic test_random();
        for (int i = 0; i < 8; i++) begin
            play_short("rand", int'($urandom_range(0, 15)),
                       int'($urandom_range(0, 31)),
                       int'($urandom_range(5, NL_S + 5)));
        end
        play_short("rand_end", 9, int'($urandom_range(1, 31)), NL_S + 3);
    endtask

    task automatic test_reset_mid();
        int pa = 20;
        play_short("mid", 7, 20, 39);
        #2;
        reset = 1'b1;
        #1;
        total++;
        if ({pwm_s, amp_s, busy_s} !== 7'd0) begin
            bad++;
            $display("FAIL async_reset got=%b want=0", {pwm_s, amp_s, busy_s});
        end
        repeat (2) step();
        reset = 1'b0;
        pa = 0;
        for (int k = 0; k < 8; k++) begin
            step();
            total++;
            if ({pwm_s, amp_s, busy_s} !== {exp_pwm(pa), 6'd0}) begin
                bad++;
                $display("FAIL post_reset k=%0d got=%b want=0",
                         k, {pwm_s, amp_s, busy_s});
            end
        end
    endtask

    initial begin
        test_reset();
        test_tone_full();
        test_tone_toggle();
        test_retrigger();
        test_stop();
        test_vol_zero();
        test_envelope();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
